// File: rtl/clause_reupdate_engine.sv
// clause_reupdate_engine: walks the clause RAM and rewrites each record's unassigned mask/active flag and gathers sat/unit/conflict status.
// Ports: clk, rst (sync, active-high); start/busy/done handshake; literal_bool/literal_assigned assignment vectors;
// mem_rd_en/mem_addr/mem_rd_data/mem_wr_en/mem_wr_data single-port RAM side; sat_count/unit_count/conflict/conflict_addr status.
module clause_reupdate_engine #(
    parameter int WIDTH        = 9,
    parameter int MAX_LITERALS = 256,
    parameter int K            = 3,
    parameter int NUM_CLAUSES  = 64,
    parameter int ADDR_W       = $clog2(NUM_CLAUSES),
    parameter int CNT_W        = $clog2(NUM_CLAUSES + 1),
    parameter int REC_W        = K * WIDTH + K + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [MAX_LITERALS-1:0] literal_bool,
    input  logic [MAX_LITERALS-1:0] literal_assigned,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [REC_W-1:0]        mem_rd_data,
    output logic                    mem_wr_en,
    output logic [REC_W-1:0]        mem_wr_data,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        sat_count,
    output logic [CNT_W-1:0]        unit_count,
    output logic                    conflict,
    output logic [ADDR_W-1:0]       conflict_addr
);
    localparam int VW = $clog2(MAX_LITERALS);
    localparam int UW = $clog2(K + 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_CLAUSES - 1);

    typedef enum logic [1:0] {IDLE, RD, EVAL, WR} state_t;

    state_t                  state;
    logic [ADDR_W-1:0]       addr;
    logic [K-1:0][WIDTH-1:0] lit;
    logic [K-1:0][VW-1:0]    idx;
    logic [K-1:0]            pad, neg, asg, val, mtmp, unasg, mask_in;
    logic [UW-1:0]           ucnt;
    logic                    sat, rec_valid, active_out, is_sat, is_unit, is_conflict;
    logic [REC_W-1:0]        rec_out;

    assign mem_addr  = addr;
    assign rec_valid = mem_rd_data[REC_W-1];
    assign mask_in   = mem_rd_data[K*WIDTH +: K];

    always_comb begin
        sat   = 1'b0;
        ucnt  = '0;
        lit   = '0;
        idx   = '0;
        pad   = '0;
        neg   = '0;
        asg   = '0;
        val   = '0;
        mtmp  = '0;
        unasg = '0;
        for (int j = 0; j < K; j++) begin
            lit[j]   = mem_rd_data[j*WIDTH +: WIDTH];
            pad[j]   = (lit[j] == '0);
            neg[j]   = lit[j][WIDTH-1];
            // variable index is the literal magnitude
            idx[j]   = VW'(neg[j] ? -lit[j] : lit[j]);
            asg[j]   = ~pad[j] & literal_assigned[idx[j]];
            val[j]   = neg[j] ? ~literal_bool[idx[j]] : literal_bool[idx[j]];
            sat      = sat | (asg[j] & val[j]);
            unasg[j] = ~pad[j] & ~literal_assigned[idx[j]];
            mtmp[j]  = ~pad[j] & (mask_in[j] | ~literal_assigned[idx[j]]);
            ucnt     = ucnt + UW'(unasg[j]);
        end
        active_out  = ~sat & (mem_rd_data[REC_W-2] | (|mtmp));
        rec_out     = {rec_valid, active_out, mtmp & {K{~sat}}, mem_rd_data[K*WIDTH-1:0]};
        is_sat      = rec_valid & sat;
        is_unit     = rec_valid & ~sat & (ucnt == UW'(1));
        // an all-padded clause has no unassigned literal and no satisfier, so it lands here too
        is_conflict = rec_valid & ~sat & (ucnt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr          <= '0;
            mem_rd_en     <= 1'b0;
            mem_wr_en     <= 1'b0;
            mem_wr_data   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            sat_count     <= '0;
            unit_count    <= '0;
            conflict      <= 1'b0;
            conflict_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state         <= RD;
                        addr          <= '0;
                        mem_rd_en     <= 1'b1;
                        busy          <= 1'b1;
                        sat_count     <= '0;
                        unit_count    <= '0;
                        conflict      <= 1'b0;
                        conflict_addr <= '0;
                    end
                end
                RD: begin
                    mem_rd_en <= 1'b0;
                    state     <= EVAL;
                end
                EVAL: begin
                    state       <= WR;
                    mem_wr_en   <= rec_valid;
                    mem_wr_data <= rec_out;
                    done        <= (addr == LAST);
                    if (is_sat) sat_count <= sat_count + CNT_W'(1);
                    if (is_unit) unit_count <= unit_count + CNT_W'(1);
                    if (is_conflict) begin
                        conflict <= 1'b1;
                        if (!conflict) conflict_addr <= addr;
                    end
                end
                WR: begin
                    mem_wr_en <= 1'b0;
                    done      <= 1'b0;
                    if (addr == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        addr      <= addr + ADDR_W'(1);
                        mem_rd_en <= 1'b1;
                        state     <= RD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clause_reupdate_engine.sv
// tb_clause_reupdate_engine: directed self-checking bench with a behavioural clause RAM.
module tb_clause_reupdate_engine;
    localparam int NC = 8;
    localparam int W  = 9;
    localparam int ML = 256;
    localparam int KK = 3;
    localparam int AW = 3;
    localparam int CW = 4;
    localparam int RW = KK * W + KK + 2;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [ML-1:0] lb, la;
    logic          mem_rd_en, mem_wr_en, busy, done, conflict;
    logic [AW-1:0] mem_addr, conflict_addr;
    logic [RW-1:0] mem_rd_data, mem_wr_data;
    logic [CW-1:0] sat_count, unit_count;

    logic [RW-1:0] mem [NC];
    logic [RW-1:0] img [NC];
    int            wr_cnt [NC];
    logic          ld, clr;
    int            errors = 0;
    int            checks = 0;

    clause_reupdate_engine #(.WIDTH(W), .MAX_LITERALS(ML), .K(KK), .NUM_CLAUSES(NC)) dut (
        .clk(clk), .rst(rst), .start(start),
        .literal_bool(lb), .literal_assigned(la),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .busy(busy), .done(done), .sat_count(sat_count), .unit_count(unit_count),
        .conflict(conflict), .conflict_addr(conflict_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
        if (ld) for (int i = 0; i < NC; i++) mem[i] <= img[i];
        else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        if (ld || clr) for (int i = 0; i < NC; i++) wr_cnt[i] <= 0;
        else if (mem_wr_en) wr_cnt[mem_addr] <= wr_cnt[mem_addr] + 1;
    end

    function automatic logic [RW-1:0] mk(input logic v, input logic a, input logic [KK-1:0] m,
                                         input logic [W-1:0] l0, input logic [W-1:0] l1, input logic [W-1:0] l2);
        return {v, a, m, l2, l1, l0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load();
        @(negedge clk) ld = 1'b1;
        @(negedge clk) ld = 1'b0;
    endtask

    task automatic run_pass(input string tag, input bit restart5);
        int done_at, pulses, busy_bad;
        done_at = -1; pulses = 0; busy_bad = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 1; c <= 3 * NC + 6; c++) begin
            if (done) begin
                pulses++;
                if (done_at < 0) done_at = c;
            end
            if (busy !== (c <= 3 * NC)) busy_bad++;
            if (restart5 && c == 5) start = 1'b1;
            if (c == 6) start = 1'b0;
            @(negedge clk);
        end
        chk({tag, "_done_cycle"}, 64'(done_at), 64'(3 * NC));
        chk({tag, "_done_pulses"}, 64'(pulses), 64'd1);
        chk({tag, "_busy_window"}, 64'(busy_bad), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ld = 1'b0; clr = 1'b0; lb = '0; la = '0;
        for (int i = 0; i < NC; i++) img[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_wr_en", 64'(mem_wr_en), 64'd0);
        chk("rst_wr_data", 64'(mem_wr_data), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_counts", 64'({sat_count, unit_count, conflict, conflict_addr}), 64'd0);
        rst = 1'b0;

        // unit and conflict: first conflict in address order is clause B at 5
        la[1] = 1'b1; lb[1] = 1'b0;
        la[3] = 1'b1; lb[3] = 1'b1;
        img[2] = mk(1, 0, 3'b000, 9'sd1, 9'sd2, 9'sd0);
        img[3] = mk(1, 0, 3'b111, -9'sd1, 9'sd0, 9'sd0);
        img[4] = mk(1, 0, 3'b001, 9'sd1, 9'sd2, 9'sd0);
        img[5] = mk(1, 1, 3'b000, -9'sd3, 9'sd0, 9'sd0);
        img[6] = mk(1, 0, 3'b000, 9'sd0, 9'sd0, 9'sd0);
        img[7] = mk(1, 0, 3'b000, -9'sd3, 9'sd0, 9'sd0);
        load();
        run_pass("B", 1'b1);
        chk("B_sat_count", 64'(sat_count), 64'd1);
        chk("B_unit_count", 64'(unit_count), 64'd2);
        chk("B_conflict", 64'(conflict), 64'd1);
        chk("B_conflict_addr", 64'(conflict_addr), 64'd5);
        chk("B_rec2_mask", 64'(mem[2]), 64'(mk(1, 1, 3'b010, 9'sd1, 9'sd2, 9'sd0)));
        chk("B_rec3_sat", 64'(mem[3]), 64'(mk(1, 0, 3'b000, -9'sd1, 9'sd0, 9'sd0)));
        chk("B_rec4_keep", 64'(mem[4]), 64'(mk(1, 1, 3'b011, 9'sd1, 9'sd2, 9'sd0)));
        chk("B_rec5", 64'(mem[5]), 64'(mk(1, 1, 3'b000, -9'sd3, 9'sd0, 9'sd0)));
        chk("B_rec7", 64'(mem[7]), 64'(mk(1, 0, 3'b000, -9'sd3, 9'sd0, 9'sd0)));
        chk("B_writes", 64'(wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[7]), 64'd2);

        // satisfied clause, backtrack restore, invalid record
        la = '0; lb = '0;
        la[5] = 1'b1; lb[5] = 1'b1;
        for (int i = 0; i < NC; i++) img[i] = '0;
        img[0] = mk(1, 1, 3'b000, 9'sd5, -9'sd7, 9'sd2);
        img[1] = mk(0, 1, 3'b101, 9'sd3, 9'sd0, 9'sd0);
        img[2] = mk(1, 0, 3'b000, 9'sd4, -9'sd6, 9'sd9);
        load();
        run_pass("A", 1'b0);
        chk("A_sat_count", 64'(sat_count), 64'd1);
        chk("A_unit_count", 64'(unit_count), 64'd0);
        chk("A_conflict", 64'(conflict), 64'd0);
        chk("A_rec0", 64'(mem[0]), 64'(mk(1, 0, 3'b000, 9'sd5, -9'sd7, 9'sd2)));
        chk("A_rec1_untouched", 64'(mem[1]), 64'(mk(0, 1, 3'b101, 9'sd3, 9'sd0, 9'sd0)));
        chk("A_rec2_restore", 64'(mem[2]), 64'(mk(1, 1, 3'b111, 9'sd4, -9'sd6, 9'sd9)));
        chk("A_wr_addr1", 64'(wr_cnt[1]), 64'd0);
        chk("A_writes", 64'(wr_cnt[0] + wr_cnt[2] + wr_cnt[3]), 64'd2);

        // reset in the middle of a pass
        load();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        chk("C_c4_addr", 64'(mem_addr), 64'd1);
        chk("C_c4_rd_en", 64'(mem_rd_en), 64'd1);
        chk("C_c4_sat_count", 64'(sat_count), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("C_c5_busy", 64'(busy), 64'd0);
        chk("C_c5_strobes", 64'({mem_rd_en, mem_wr_en, done}), 64'd0);
        chk("C_c5_wr_data", 64'(mem_wr_data), 64'd0);
        chk("C_c5_addr", 64'(mem_addr), 64'd0);
        chk("C_c5_sat_count", 64'(sat_count), 64'd0);
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        begin
            int strobes;
            strobes = 0;
            for (int c = 0; c < 4; c++) begin
                if (mem_rd_en || mem_wr_en || busy) strobes++;
                @(negedge clk);
            end
            chk("C_idle_strobes", 64'(strobes), 64'd0);
        end
        chk("C_idle_writes", 64'(wr_cnt[0] + wr_cnt[1]), 64'd0);

        run_pass("D", 1'b0);
        chk("D_sat_count", 64'(sat_count), 64'd1);
        chk("D_unit_conflict", 64'({unit_count, conflict}), 64'd0);
        chk("D_rec0", 64'(mem[0]), 64'(mk(1, 0, 3'b000, 9'sd5, -9'sd7, 9'sd2)));
        chk("D_rec2", 64'(mem[2]), 64'(mk(1, 1, 3'b111, 9'sd4, -9'sd6, 9'sd9)));
        chk("D_writes", 64'({wr_cnt[0][3:0], wr_cnt[1][3:0], wr_cnt[2][3:0]}), 64'h101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
